// File: rtl/pc_fetch_ctrl_if.sv
// Bundle of branch inputs, instruction-memory handshake and execute-window
// outputs shared between the fetch controller and its surroundings.
interface pc_fetch_ctrl_if;
  logic        br_en;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic [31:0] bad_addr;

  modport master (
    input  br_en, br_taken, br_target, stall, imem_ack,
    output imem_req, imem_addr, instr_valid, pc, pc_plus4, misaligned, bad_addr
  );

  modport slave (
    output br_en, br_taken, br_target, stall, imem_ack,
    input  imem_req, imem_addr, instr_valid, pc, pc_plus4, misaligned, bad_addr
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC register and fetch/execute sequencer: fetches pc, holds the instruction
// for one execute window, then advances, branches, or traps on misalignment.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input logic                  clk,
  input logic                  rst,
  pc_fetch_ctrl_if.master      bus
);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] bad_addr_q, bad_addr_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      bad_addr_q   <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      bad_addr_q   <= bad_addr_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    bad_addr_d   = bad_addr_q;
    misaligned_d = 1'b0;
    next_pc      = (bus.br_en && bus.br_taken) ? bus.br_target : pc_plus4;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: if (bus.imem_ack) state_d = EXEC;
      EXEC: begin
        if (!bus.stall) begin
          state_d = FETCH;
          // A misaligned target never reaches pc; it is reported and replaced.
          if (next_pc[1:0] == 2'b00) begin
            pc_d = next_pc;
          end else begin
            pc_d         = TRAP_VECTOR;
            bad_addr_d   = next_pc;
            misaligned_d = 1'b1;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Decoded from state so reset drops the request without waiting for a clock.
  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == EXEC);
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.misaligned  = misaligned_q;
  assign bus.bad_addr    = bad_addr_q;

  a_vectors_aligned: assert property (@(posedge clk)
    (RESET_VECTOR[1:0] == 2'b00) && (TRAP_VECTOR[1:0] == 2'b00));

  a_pc_aligned: assert property (@(posedge clk) disable iff (rst)
    pc_q[1:0] == 2'b00);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a cycle-level behavioural model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_pc_fetch_ctrl;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: where the program counter is, whether the boot cycle is still
  // pending, and whether an instruction has been fetched and awaits retirement.
  logic [31:0] m_pc, m_bad;
  logic        m_boot, m_have_instr, m_mis;

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic en,
                                             input logic tk, input logic [31:0] tgt);
    if (en && tk) return tgt;
    return cur + 32'd4;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0; m_bad <= 32'h0; m_boot <= 1'b1; m_have_instr <= 1'b0; m_mis <= 1'b0;
    end else begin
      m_mis <= 1'b0;
      if (m_boot) begin
        m_boot <= 1'b0;
      end else if (!m_have_instr) begin
        if (bus.imem_ack) m_have_instr <= 1'b1;
      end else if (!bus.stall) begin
        m_have_instr <= 1'b0;
        if (model_next(m_pc, bus.br_en, bus.br_taken, bus.br_target) % 4 == 0) begin
          m_pc <= model_next(m_pc, bus.br_en, bus.br_taken, bus.br_target);
        end else begin
          m_pc  <= 32'h0000_0100;
          m_bad <= model_next(m_pc, bus.br_en, bus.br_taken, bus.br_target);
          m_mis <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("m_req",   {31'd0, bus.imem_req},    {31'd0, !m_boot && !m_have_instr});
      chk("m_valid", {31'd0, bus.instr_valid}, {31'd0, m_have_instr});
      chk("m_pc",    bus.pc,       m_pc);
      chk("m_pc4",   bus.pc_plus4, m_pc + 32'd4);
      chk("m_mis",   {31'd0, bus.misaligned}, {31'd0, m_mis});
      chk("m_bad",   bus.bad_addr, m_bad);
      if (!m_boot && !m_have_instr) chk("m_addr", bus.imem_addr, m_pc);
    end
  end

  task automatic go_exec();
    int n = 0;
    while (bus.instr_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.instr_valid !== 1'b1) begin
      n_vec++;
      n_miss++;
      $display("FAIL go_exec: timeout waiting for instr_valid got %b want 1", bus.instr_valid);
    end
  endtask

  task automatic exec_branch(input logic en, input logic tk, input logic [31:0] tgt);
    bus.br_en = en; bus.br_taken = tk; bus.br_target = tgt;
    @(negedge clk);
    bus.br_en = 1'b0; bus.br_taken = 1'b0; bus.br_target = 32'h0;
  endtask

  task automatic jump_to(input logic [31:0] a);
    go_exec();
    exec_branch(1'b1, 1'b1, a);
    go_exec();
  endtask

  initial begin
    rst = 1'b1;
    bus.br_en = 1'b0; bus.br_taken = 1'b0; bus.br_target = 32'h0;
    bus.stall = 1'b0; bus.imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc",    bus.pc, 32'h0);
    chk("rst_req",   {31'd0, bus.imem_req},    32'd0);
    chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_mis",   {31'd0, bus.misaligned},  32'd0);
    chk("rst_bad",   bus.bad_addr, 32'h0);

    // Sequential fetch with zero-wait memory.
    bus.imem_ack = 1'b1;
    rst = 1'b0;
    chk("boot_req", {31'd0, bus.imem_req}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("seq_valid", {31'd0, bus.instr_valid}, k % 2);
      if (k % 2 == 0) chk("seq_addr", bus.imem_addr, 32'(4 * (k / 2)));
    end

    // Branch taken / not taken / not a branch.
    exec_branch(1'b1, 1'b1, 32'h40);
    chk("br_to40", bus.imem_addr, 32'h40);
    go_exec();
    exec_branch(1'b1, 1'b1, 32'h80);
    chk("br_taken", bus.imem_addr, 32'h80);
    jump_to(32'h40);
    exec_branch(1'b1, 1'b0, 32'h80);
    chk("br_not_taken", bus.imem_addr, 32'h44);
    jump_to(32'h40);
    exec_branch(1'b0, 1'b1, 32'h80);
    chk("br_en_low", bus.imem_addr, 32'h44);

    // Ack delayed by three cycles.
    go_exec();
    bus.imem_ack = 1'b0;
    exec_branch(1'b1, 1'b1, 32'h10);
    for (int i = 0; i < 4; i++) begin
      chk("wait_req",   {31'd0, bus.imem_req},    32'd1);
      chk("wait_addr",  bus.imem_addr, 32'h10);
      chk("wait_valid", {31'd0, bus.instr_valid}, 32'd0);
      if (i == 3) bus.imem_ack = 1'b1;
      @(negedge clk);
    end
    chk("wait_done", {31'd0, bus.instr_valid}, 32'd1);

    // Two-cycle stall in execute.
    jump_to(32'h20);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("stall_pc",    bus.pc, 32'h20);
      if (i == 2) bus.stall = 1'b0;
      @(negedge clk);
    end
    chk("stall_next", bus.imem_addr, 32'h24);

    // Misaligned redirect traps.
    go_exec();
    exec_branch(1'b1, 1'b1, 32'h1002);
    chk("trap_mis",  {31'd0, bus.misaligned}, 32'd1);
    chk("trap_bad",  bus.bad_addr,  32'h1002);
    chk("trap_addr", bus.imem_addr, 32'h100);
    @(negedge clk);
    chk("trap_pulse", {31'd0, bus.misaligned}, 32'd0);
    chk("trap_hold",  bus.bad_addr, 32'h1002);

    // pc+4 wraps at the top of the address space.
    jump_to(32'hFFFF_FFFC);
    chk("wrap_pc4", bus.pc_plus4, 32'h0);
    exec_branch(1'b0, 1'b0, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    // Reset in the middle of a pending fetch.
    go_exec();
    bus.imem_ack = 1'b0;
    exec_branch(1'b1, 1'b1, 32'h300);
    @(negedge clk);
    chk("pre_rst_req", {31'd0, bus.imem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_req", {31'd0, bus.imem_req}, 32'd0);
    chk("async_pc",  bus.pc, 32'h0);
    bus.imem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rel_boot", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    chk("rel_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("rel_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    chk("rel_valid", {31'd0, bus.instr_valid}, 32'd1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
